// File: rtl/cursor_pkg.sv
// Shared types, constants and the wrap-around adder for the cursor_control block.
// The optional step acceleration is enabled with the CURSOR_ACCEL_EN macro.
package cursor_pkg;

    typedef enum logic {
        AXIS_X = 1'b0,
        AXIS_Y = 1'b1
    } axis_t;

    localparam int STEP_MAX = 8;
    localparam int COORD_W  = 10;

    // Adds a signed step to a coordinate and wraps modulo (max_pos + 1).
    // The sum is formed one bit wider than the coordinate so that a negative
    // intermediate or an overshoot past max_pos is seen before truncation.
    function automatic logic [COORD_W-1:0] wrap_add(
        input logic [COORD_W-1:0] pos,
        input logic signed [4:0]  step,
        input logic [COORD_W-1:0] max_pos
    );
        logic signed [COORD_W:0] sum;
        logic signed [COORD_W:0] lim;
        logic signed [COORD_W:0] adj;
        sum = $signed({1'b0, pos}) + $signed({{(COORD_W-4){step[4]}}, step});
        lim = $signed({1'b0, max_pos});
        if (sum[COORD_W]) begin
            adj = sum + lim + 11'sd1;
        end else if (sum > lim) begin
            adj = sum - lim - 11'sd1;
        end else begin
            adj = sum;
        end
        return adj[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/cursor_accel.sv
// Step-size accelerator for cursor_control: step doubles 1->2->4->8 while
// same-direction detents keep arriving inside the window. Built only when
// CURSOR_ACCEL_EN is defined.
`ifdef CURSOR_ACCEL_EN
module cursor_accel
    import cursor_pkg::*;
#(
    parameter int ACCEL_WINDOW = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stepL,
    input  logic       stepR,
    input  logic       clear,
    output logic [3:0] step
);

    localparam int              CNT_W    = $clog2(ACCEL_WINDOW + 1);
    localparam logic [CNT_W-1:0] WIN     = CNT_W'(ACCEL_WINDOW);
    localparam logic [3:0]      STEP_CAP = 4'(STEP_MAX);

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_L    = 2'd1,
        DIR_R    = 2'd2
    } dir_t;

    logic [CNT_W-1:0] r_cnt;
    dir_t             r_dir;
    logic [3:0]       r_step;

    logic             w_accept;
    dir_t             w_dir;
    logic [3:0]       w_step_next;

    // Decide the step for the current pulse; the move uses the updated value.
    always_comb begin
        w_accept    = stepL | stepR;
        w_dir       = DIR_NONE;
        w_step_next = r_step;
        if (stepR) begin
            w_dir = DIR_R;
        end else if (stepL) begin
            w_dir = DIR_L;
        end else begin
            w_dir = DIR_NONE;
        end
        if (clear) begin
            w_step_next = 4'd1;
        end else if (w_accept) begin
            if ((w_dir == r_dir) && (r_cnt < WIN)) begin
                if (r_step >= STEP_CAP) begin
                    w_step_next = STEP_CAP;
                end else begin
                    w_step_next = {r_step[2:0], 1'b0};
                end
            end else begin
                w_step_next = 4'd1;
            end
        end else begin
            w_step_next = r_step;
        end
    end

    assign step = w_step_next;

    // Track step size, last direction and the saturating window counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_dir  <= DIR_NONE;
            r_step <= 4'd1;
        end else begin
            r_step <= w_step_next;
            if (w_accept) begin
                r_cnt <= '0;
                r_dir <= w_dir;
            end else begin
                if (r_cnt < WIN) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (clear) begin
                    r_dir <= DIR_NONE;
                end
            end
        end
    end

endmodule
`endif

// File: rtl/cursor_control.sv
// Rotary-encoder cursor: left/right detents move the cursor along the selected
// axis with wrap-around, a button press toggles between X and Y.
// Optional step acceleration is enabled with the CURSOR_ACCEL_EN macro.
module cursor_control
    import cursor_pkg::*;
#(
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479,
    parameter int X_INIT       = 320,
    parameter int Y_INIT       = 240,
    parameter int ACCEL_WINDOW = 2500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic               right,
    input  logic               down,
    output logic [COORD_W-1:0] cursorX,
    output logic [COORD_W-1:0] cursorY,
    output logic               axisY,
    output logic               moved
);

    localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C  = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] X_INIT_C = COORD_W'(X_INIT);
    localparam logic [COORD_W-1:0] Y_INIT_C = COORD_W'(Y_INIT);

    axis_t              r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_axis_y;
    logic               r_moved;

    logic               w_step_l;
    logic               w_step_r;
    logic [3:0]         w_step;
    logic signed [4:0]  w_delta;
    logic               w_move;
    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;

    // Opposing detents in the same cycle cancel and are not a step.
    assign w_step_l = left  & ~right;
    assign w_step_r = right & ~left;
    assign w_move   = w_step_l | w_step_r;

`ifdef CURSOR_ACCEL_EN
    cursor_accel #(
        .ACCEL_WINDOW (ACCEL_WINDOW)
    ) u_accel (
        .clk   (clk),
        .rst   (rst),
        .stepL (w_step_l),
        .stepR (w_step_r),
        .clear (down),
        .step  (w_step)
    );
`else
    logic w_unused_accel;
    assign w_unused_accel = (ACCEL_WINDOW != 0);
    assign w_step         = 4'd1;
`endif

    // Form the signed step and the wrapped candidate coordinates.
    always_comb begin
        w_delta = 5'sd0;
        if (w_step_r) begin
            w_delta = $signed({1'b0, w_step});
        end else if (w_step_l) begin
            w_delta = -$signed({1'b0, w_step});
        end else begin
            w_delta = 5'sd0;
        end
        w_x_next = wrap_add(r_x, w_delta, X_MAX_C);
        w_y_next = wrap_add(r_y, w_delta, Y_MAX_C);
    end

    // Axis FSM plus coordinate registers; a move uses the axis selected before any toggle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= AXIS_X;
            r_axis_y <= 1'b0;
            r_x      <= X_INIT_C;
            r_y      <= Y_INIT_C;
            r_moved  <= 1'b0;
        end else begin
            r_moved <= w_move;
            if (w_move) begin
                case (r_state)
                    AXIS_X:  r_x <= w_x_next;
                    AXIS_Y:  r_y <= w_y_next;
                    default: r_x <= r_x;
                endcase
            end
            if (down) begin
                case (r_state)
                    AXIS_X: begin
                        r_state  <= AXIS_Y;
                        r_axis_y <= 1'b1;
                    end
                    AXIS_Y: begin
                        r_state  <= AXIS_X;
                        r_axis_y <= 1'b0;
                    end
                    default: begin
                        r_state  <= AXIS_X;
                        r_axis_y <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cursorX = r_x;
    assign cursorY = r_y;
    assign axisY   = r_axis_y;
    assign moved   = r_moved;

endmodule

// File: tb/tb_cursor_control.sv
// Scoreboard bench for cursor_control: stimulus pushes the expected coordinate
// on every accepted step, a negedge monitor pops and compares on each moved strobe.
module tb_cursor_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       left;
    logic       right;
    logic       down;
    logic [9:0] cursorX;
    logic [9:0] cursorY;
    logic       axisY;
    logic       moved;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       ay;
    } exp_t;

    exp_t sb[$];
    int   total     = 0;
    int   bad       = 0;
    int   moved_cnt = 0;
    int   mx;
    int   my;
    logic ma;
    int   snap;

    cursor_control #(
        .X_MAX        (639),
        .Y_MAX        (479),
        .X_INIT       (320),
        .Y_INIT       (240),
        .ACCEL_WINDOW (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .left    (left),
        .right   (right),
        .down    (down),
        .cursorX (cursorX),
        .cursorY (cursorY),
        .axisY   (axisY),
        .moved   (moved)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One-cycle pulse on the chosen inputs, sampled at the next rising edge.
    task automatic pulse(input logic l, input logic r, input logic d);
        left  = l;
        right = r;
        down  = d;
        @(posedge clk);
        #1;
        left  = 1'b0;
        right = 1'b0;
        down  = 1'b0;
    endtask

    task automatic push();
        exp_t e;
        e.x  = mx[9:0];
        e.y  = my[9:0];
        e.ay = ma;
        sb.push_back(e);
    endtask

    // Monitor: every moved strobe must match the oldest expected entry.
    always @(negedge clk) begin
        if (moved) begin
            moved_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_moved actual=1 required=0 x=%0d y=%0d", cursorX, cursorY);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("move_x", int'(cursorX), int'(e.x));
                chk("move_y", int'(cursorY), int'(e.y));
                chk("move_axis", int'(axisY), int'(e.ay));
            end
        end
    end

    initial begin
        int exp_seq[7];
`ifdef CURSOR_ACCEL_EN
        exp_seq = '{321, 323, 327, 335, 343, 344, 343};
`else
        exp_seq = '{321, 322, 323, 324, 325, 326, 325};
`endif
        rst   = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        down  = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        chk("reset_x", int'(cursorX), 320);
        chk("reset_y", int'(cursorY), 240);
        chk("reset_axis", int'(axisY), 0);
        chk("reset_moved", int'(moved), 0);
        mx = 320;
        my = 240;
        ma = 1'b0;

        // X wrap downwards through zero
        for (int i = 0; i < 321; i++) begin
            mx = (mx == 0) ? 639 : mx - 1;
            push();
            pulse(1'b1, 1'b0, 1'b0);
            idle(1);
        end
        chk("wrap_left_x", int'(cursorX), 639);
        chk("wrap_left_y", int'(cursorY), 240);
        mx = (mx == 639) ? 0 : mx + 1;
        push();
        pulse(1'b0, 1'b1, 1'b0);
        idle(1);
        chk("wrap_right_x", int'(cursorX), 0);
        chk("moved_count", moved_cnt, 322);

        // Axis toggle and moves on Y
        pulse(1'b0, 1'b0, 1'b1);
        ma = 1'b1;
        idle(1);
        chk("toggle_axis", int'(axisY), 1);
        for (int i = 0; i < 3; i++) begin
            my = my + 1;
            push();
            pulse(1'b0, 1'b1, 1'b0);
            idle(1);
        end
        chk("y_after_right", int'(cursorY), 243);
        chk("x_untouched", int'(cursorX), 0);
        my = 242;
        ma = 1'b0;
        push();
        pulse(1'b1, 1'b0, 1'b1);
        idle(1);
        chk("down_left_axis", int'(axisY), 0);
        chk("down_left_y", int'(cursorY), 242);

        // Opposing detents cancel
        snap = moved_cnt;
        pulse(1'b1, 1'b1, 1'b0);
        idle(1);
        chk("both_moved_cnt", moved_cnt, snap);
        chk("both_x", int'(cursorX), 0);
        chk("both_y", int'(cursorY), 242);

        // Reset wins over a same-cycle pulse
        rst   = 1'b0;
        right = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b1;
        right = 1'b0;
        chk("rst_pulse_x", int'(cursorX), 320);
        chk("rst_pulse_y", int'(cursorY), 240);
        chk("rst_pulse_axis", int'(axisY), 0);
        chk("rst_pulse_moved", int'(moved), 0);
        idle(1);
        chk("rst_pulse_cnt", moved_cnt, snap);
        mx = 320;
        my = 240;
        ma = 1'b0;

        // Step sequence: five right detents four cycles apart
        for (int i = 0; i < 5; i++) begin
            mx = exp_seq[i];
            push();
            pulse(1'b0, 1'b1, 1'b0);
            idle(3);
        end
        idle(7);
        mx = exp_seq[5];
        push();
        pulse(1'b0, 1'b1, 1'b0);
        idle(1);
        mx = exp_seq[6];
        push();
        pulse(1'b1, 1'b0, 1'b0);
        idle(2);
        chk("seq_final_x", int'(cursorX), exp_seq[6]);
        chk("seq_y", int'(cursorY), 240);
        chk("scoreboard_drain", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
